// File: rtl/counter_arbiter.sv
// Round-robin owner of one shared up-counter used as a delay timer by two requesters.
// done pulses len+1 edges after grant; the loser's req simply waits at level, nothing is queued.
module counter_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             req0,
  input  logic [WIDTH-1:0] len0,
  input  logic             req1,
  input  logic [WIDTH-1:0] len1,
  output logic             grant0,
  output logic             grant1,
  output logic             done0,
  output logic             done1,
  output logic             busy,
  output logic [WIDTH-1:0] count
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic             grant0_nxt, grant1_nxt, done0_nxt, done1_nxt;
  logic [WIDTH-1:0] count_nxt, target, target_nxt;
  logic             prio, prio_nxt;
  logic             win;
  logic             owner;
  logic             owner_req;

  // Grants are exclusive, so grant1 alone identifies the current owner.
  assign owner     = grant1;
  assign owner_req = owner ? req1 : req0;
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt  = state;
    grant0_nxt = grant0;
    grant1_nxt = grant1;
    done0_nxt  = 1'b0;
    done1_nxt  = 1'b0;
    count_nxt  = count;
    target_nxt = target;
    prio_nxt   = prio;
    win        = 1'b0;
    case (state)
      IDLE: begin
        count_nxt = '0;
        if (req0 || req1) begin
          win        = (req0 && req1) ? prio : req1;
          grant0_nxt = ~win;
          grant1_nxt = win;
          target_nxt = win ? len1 : len0;
          state_nxt  = RUN;
        end
      end
      RUN: begin
        // Abort takes precedence over the terminal compare.
        if (!owner_req) begin
          state_nxt  = IDLE;
          grant0_nxt = 1'b0;
          grant1_nxt = 1'b0;
          count_nxt  = '0;
          prio_nxt   = ~owner;
        end else if (count == target) begin
          state_nxt = DONE;
          done0_nxt = ~owner;
          done1_nxt = owner;
        end else begin
          count_nxt = count + WIDTH'(1);
        end
      end
      DONE: begin
        state_nxt  = IDLE;
        grant0_nxt = 1'b0;
        grant1_nxt = 1'b0;
        count_nxt  = '0;
        prio_nxt   = ~owner;
      end
      default: begin
        state_nxt  = IDLE;
        grant0_nxt = 1'b0;
        grant1_nxt = 1'b0;
        count_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state  <= IDLE;
      grant0 <= 1'b0;
      grant1 <= 1'b0;
      done0  <= 1'b0;
      done1  <= 1'b0;
      count  <= '0;
      target <= '0;
      prio   <= 1'b0;
    end else begin
      state  <= state_nxt;
      grant0 <= grant0_nxt;
      grant1 <= grant1_nxt;
      done0  <= done0_nxt;
      done1  <= done1_nxt;
      count  <= count_nxt;
      target <= target_nxt;
      prio   <= prio_nxt;
    end
  end

endmodule

// File: tb/tb_counter_arbiter.sv
// Directed and randomized checks of counter_arbiter against a timeline model
// (owner, edges since grant, latched length).
module tb_counter_arbiter;

  localparam int W = 4;

  logic         clock = 1'b0;
  logic         clear = 1'b1;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0] len0 = '0, len1 = '0;
  logic         grant0, grant1, done0, done1, busy;
  logic [W-1:0] count;

  int total = 0;
  int bad   = 0;

  // Model: who owns the counter, how many edges since the grant, latched length, priority.
  int m_owner = -1;
  int m_age   = 0;
  int m_tlen  = 0;
  int m_prio  = 0;

  counter_arbiter #(.WIDTH(W)) dut (
    .clock (clock),
    .clear (clear),
    .req0  (req0),
    .len0  (len0),
    .req1  (req1),
    .len1  (len1),
    .grant0(grant0),
    .grant1(grant1),
    .done0 (done0),
    .done1 (done1),
    .busy  (busy),
    .count (count)
  );

  always #5 clock = ~clock;

  // Advance one rising edge, update the model from the inputs seen at that edge,
  // and return 1 time unit later so outputs are sampled away from the edge.
  task automatic step();
    int w;
    int r;
    @(posedge clock);
    if (clear) begin
      m_owner = -1;
      m_age   = 0;
      m_prio  = 0;
    end else if (m_owner < 0) begin
      if (req0 || req1) begin
        w       = (req0 && req1) ? m_prio : (req1 ? 1 : 0);
        m_owner = w;
        m_age   = 0;
        m_tlen  = (w == 1) ? int'(len1) : int'(len0);
      end
    end else begin
      r = (m_owner == 1) ? int'(req1) : int'(req0);
      if (m_age <= m_tlen && r == 0) begin
        m_prio  = 1 - m_owner;
        m_owner = -1;
      end else if (m_age == m_tlen + 1) begin
        m_prio  = 1 - m_owner;
        m_owner = -1;
      end else begin
        m_age++;
      end
    end
    #1;
  endtask

  task automatic settle();
    req0  = 1'b0;
    req1  = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    clear = 1'b1; req0 = 1'b1; req1 = 1'b1; len0 = 4'd2; len1 = 4'd2;
    step();
    step();
    total++;
    if ({grant0, grant1, done0, done1, busy, count} !== 9'd0) begin
      bad++;
      $display("FAIL reset_outputs got g=%b%b d=%b%b busy=%b count=%0d want all 0",
               grant0, grant1, done0, done1, busy, count);
    end
    clear = 1'b0;
    step();
    total++;
    if (grant0 !== 1'b1 || grant1 !== 1'b0) begin
      bad++;
      $display("FAIL reset_first_grant got g0=%b g1=%b want g0=1 g1=0", grant0, grant1);
    end
    settle();
  endtask

  task automatic test_single();
    req0 = 1'b1; len0 = 4'd3;
    step();
    total++;
    if (grant0 !== 1'b1 || count !== 4'd0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL single_grant got g0=%b count=%0d busy=%b want 1 0 1", grant0, count, busy);
    end
    len0 = 4'd9;  // must be ignored after the grant edge
    for (int i = 1; i <= 3; i++) begin
      step();
      total++;
      if (count !== 4'(i) || done0 !== 1'b0) begin
        bad++;
        $display("FAIL single_count got count=%0d done0=%b want %0d 0", count, done0, i);
      end
    end
    step();
    total++;
    if (done0 !== 1'b1 || grant0 !== 1'b1 || count !== 4'd3) begin
      bad++;
      $display("FAIL single_done got done0=%b g0=%b count=%0d want 1 1 3", done0, grant0, count);
    end
    req0 = 1'b0;  // drop during DONE is harmless
    step();
    total++;
    if (grant0 !== 1'b0 || busy !== 1'b0 || done0 !== 1'b0 || count !== 4'd0) begin
      bad++;
      $display("FAIL single_release got g0=%b busy=%b done0=%b count=%0d want 0 0 0 0",
               grant0, busy, done0, count);
    end
    settle();
  endtask

  task automatic test_round_robin();
    int order[$];
    int nd0 = 0, nd1 = 0;
    logic pg0 = 1'b0, pg1 = 1'b0;
    req0 = 1'b1; req1 = 1'b1; len0 = 4'd2; len1 = 4'd1;
    for (int c = 0; c < 20; c++) begin
      step();
      if (grant0 && !pg0) begin
        order.push_back(0);
        total++;
        if (pg1) begin bad++; $display("FAIL rr_gap grant0 rose directly after grant1 got 1 want 0"); end
      end
      if (grant1 && !pg1) begin
        order.push_back(1);
        total++;
        if (pg0) begin bad++; $display("FAIL rr_gap grant1 rose directly after grant0 got 1 want 0"); end
      end
      total++;
      if (grant0 && grant1) begin bad++; $display("FAIL rr_exclusive got g0=1 g1=1 want not both"); end
      nd0 += int'(done0);
      nd1 += int'(done1);
      pg0 = grant0;
      pg1 = grant1;
    end
    total++;
    if (order.size() < 4 || order[0] != 0 || order[1] != 1 || order[2] != 0 || order[3] != 1) begin
      bad++;
      $display("FAIL rr_order got size=%0d first=%p want 0,1,0,1", order.size(), order);
    end
    total++;
    if (nd0 < 2 || nd1 < 2) begin
      bad++;
      $display("FAIL rr_dones got done0=%0d done1=%0d want >=2 each", nd0, nd1);
    end
    settle();
  endtask

  task automatic test_abort();
    int n = 0;
    req1 = 1'b1; len1 = 4'd7;
    step();
    while (count !== 4'd2 && n < 20) begin step(); n++; end
    total++;
    if (count !== 4'd2) begin
      bad++;
      $display("FAIL abort_wait got count=%0d want 2 within 20 cycles", count);
    end
    req1 = 1'b0; req0 = 1'b1; len0 = 4'd1;
    step();
    total++;
    if (grant1 !== 1'b0 || count !== 4'd0 || busy !== 1'b0 || done1 !== 1'b0 || grant0 !== 1'b0) begin
      bad++;
      $display("FAIL abort_release got g1=%b count=%0d busy=%b done1=%b g0=%b want 0 0 0 0 0",
               grant1, count, busy, done1, grant0);
    end
    step();
    total++;
    if (grant0 !== 1'b1) begin bad++; $display("FAIL abort_next_grant got g0=%b want 1", grant0); end
    settle();
  endtask

  task automatic test_boundaries();
    req0 = 1'b1; len0 = 4'd0;
    step();
    step();
    total++;
    if (done0 !== 1'b1 || count !== 4'd0) begin
      bad++;
      $display("FAIL len0_done got done0=%b count=%0d want 1 0", done0, count);
    end
    settle();
    req0 = 1'b1; len0 = 4'd15;
    step();
    for (int i = 1; i <= 15; i++) begin
      step();
      total++;
      if (count !== 4'(i) || done0 !== 1'b0) begin
        bad++;
        $display("FAIL len15_count got count=%0d done0=%b want %0d 0", count, done0, i);
      end
    end
    step();
    total++;
    if (done0 !== 1'b1 || count !== 4'd15) begin
      bad++;
      $display("FAIL len15_done got done0=%b count=%0d want 1 15", done0, count);
    end
    settle();
  endtask

  task automatic test_reset_midrun();
    int n = 0;
    // A completed requester-0 delay moves priority to requester 1 before the run.
    req0 = 1'b1; len0 = 4'd0;
    step(); step();
    req0 = 1'b0; req1 = 1'b1; len1 = 4'd9;
    step();
    while (count !== 4'd5 && n < 20) begin step(); n++; end
    total++;
    if (count !== 4'd5 || grant1 !== 1'b1) begin
      bad++;
      $display("FAIL midrun_wait got count=%0d g1=%b want 5 1", count, grant1);
    end
    req0 = 1'b1; clear = 1'b1;
    step();
    total++;
    if ({grant0, grant1, done0, done1, busy, count} !== 9'd0) begin
      bad++;
      $display("FAIL midrun_clear got g=%b%b d=%b%b busy=%b count=%0d want all 0",
               grant0, grant1, done0, done1, busy, count);
    end
    clear = 1'b0;
    step();
    total++;
    if (grant0 !== 1'b1 || grant1 !== 1'b0) begin
      bad++;
      $display("FAIL midrun_regrant got g0=%b g1=%b want 1 0", grant0, grant1);
    end
    settle();
  endtask

  task automatic test_random();
    logic         e_g0, e_g1, e_d0, e_d1, e_busy;
    logic [W-1:0] e_cnt;
    for (int c = 0; c < 1500; c++) begin
      if (req0) req0 = ($urandom_range(0, 15) != 0); else req0 = ($urandom_range(0, 2) == 0);
      if (req1) req1 = ($urandom_range(0, 15) != 0); else req1 = ($urandom_range(0, 2) == 0);
      len0  = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 6));
      len1  = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 6));
      clear = ($urandom_range(0, 199) == 0);
      step();
      e_g0   = (m_owner == 0);
      e_g1   = (m_owner == 1);
      e_busy = (m_owner >= 0);
      e_d0   = (m_owner == 0) && (m_age == m_tlen + 1);
      e_d1   = (m_owner == 1) && (m_age == m_tlen + 1);
      e_cnt  = (m_owner < 0) ? 4'd0 : ((m_age < m_tlen) ? 4'(m_age) : 4'(m_tlen));
      total++;
      if ({grant0, grant1, done0, done1, busy, count} !== {e_g0, e_g1, e_d0, e_d1, e_busy, e_cnt}) begin
        bad++;
        $display("FAIL random cyc=%0d got g=%b%b d=%b%b busy=%b count=%0d want g=%b%b d=%b%b busy=%b count=%0d",
                 c, grant0, grant1, done0, done1, busy, count, e_g0, e_g1, e_d0, e_d1, e_busy, e_cnt);
      end
    end
    clear = 1'b0;
    settle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_abort();
    test_boundaries();
    test_reset_midrun();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/counter_arbiter.md
Name: counter_arbiter

Overview:
- Time-shares one WIDTH-bit up-counter between two requesters; each requester uses it as a programmable delay timer.
- Round-robin arbitration, a registered grant/done handshake, and abort when a requester withdraws.
- Sits between the control FSMs that need cycle delays and the shared counter resource, and sequences load, run and terminal detect.

Parameters:
- WIDTH, 4, width of the shared counter and of the length inputs.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- clear  input  1  synchronous, active-high reset.
- req0  input  1  requester 0 wants the counter; held high until done0 or abort.
- len0  input  WIDTH  requester 0 delay length; sampled only on the grant edge.
- req1  input  1  requester 1 request.
- len1  input  WIDTH  requester 1 delay length.
- grant0  output  1  counter owned by requester 0.
- grant1  output  1  counter owned by requester 1.
- done0  output  1  one-cycle pulse: requester 0 delay complete.
- done1  output  1  one-cycle pulse: requester 1 delay complete.
- busy  output  1  high whenever state is not IDLE.
- count  output  WIDTH  live value of the shared counter.

Behaviour:
- Clock and reset:
  - One clock domain.
  - clear is sampled on the rising edge of clock and overrides everything.
  - Reset values: state IDLE, grant0=grant1=0, done0=done1=0, busy=0, count=0, target=0, priority pointer prio=0 (requester 0 favoured).
- All outputs are registered or decoded directly from registers; there is no combinational path from any input to any output.
- States:
  - IDLE:
    - count held at 0.
    - If neither req is high, stay.
    - If exactly one req is high, grant it.
    - If both are high, grant the one selected by prio.
    - On grant: target <= len of the winner, count <= 0, grantX <= 1, go to RUN.
  - RUN:
    - If the owner's req is low: abort. Go to IDLE, grantX <= 0, count <= 0, no done pulse, prio <= other requester.
    - Else if count == target: go to DONE, doneX <= 1.
    - Else count <= count + 1.
  - DONE:
    - doneX is high for exactly this cycle; grantX stays high.
    - Next edge: go to IDLE, grantX <= 0, doneX <= 0, count <= 0, prio <= other requester.
- Latency: doneX rises len+1 rising edges after grantX rises. len=0 gives done one edge after grant.
- IDLE always lasts at least one cycle between ownerships, so grants never go back to back.
- The grant is exclusive: grant0 and grant1 are never high together.
- count never exceeds target, so it never wraps. len = 2^WIDTH-1 is legal (all ones).
- len changes after the grant edge are ignored. Only the latched target is used.
- The non-owner's req is ignored until the next IDLE. It is not queued beyond the level still being high.
- Abort and done are mutually exclusive: in RUN, abort is checked before the terminal compare.
- In DONE, a req drop is ignored and the done pulse still fires.
- A requester may re-raise req in the cycle after done. It then competes under the updated prio.
- clear high during RUN or DONE: immediate return to reset values; no done pulse; prio=0.

Test Plan:
- Reset: clear=1 for 2 cycles with req0=req1=1 -> all outputs 0, state IDLE; release clear -> grant0=1 on the next edge (prio=0).
- Single timer: req0=1, len0=3 -> grant0 rises at edge E0; count 0,1,2,3 on E0..E3; done0=1 for one cycle after E4; grant0=0 and busy=0 after E5.
- Round-robin: req0=req1=1 continuously, len0=2, len1=1 -> grant sequence 0,1,0,1; done0 and done1 alternate; one IDLE cycle between each grant; grant0 and grant1 never high together.
- Abort: req1=1, len1=7; drop req1 when count=2 -> next edge grant1=0, count=0, busy=0, no done1; a pending req0 is granted on the following edge.
- Boundaries, len=0 and len=15: len0=0 -> done0 one edge after grant0. len0=15 -> count reaches 15, no wrap to 0, done0 16 edges after grant0.
- Reset mid-run: assert clear while count=5 of len=9 -> outputs 0 next edge, no done pulse; after release with both reqs high, requester 0 is granted.
